// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths, constants and the fetch packet type.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int INST_W     = 32;
    localparam int ILEN_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(ILEN_BYTES);
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry hold register: captures the presented instruction on the
// first stalled edge and releases it once the consumer accepts.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       stall_i,
    input  fetch_pkt_t pkt_i,
    output logic       valid_o,
    output fetch_pkt_t pkt_o
);

    logic       valid_q, valid_d;
    fetch_pkt_t pkt_q, pkt_d;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (stall_i && !valid_q) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
        end else if (!stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: drives the sync-read ROM, pairs words with
// their PC and streams them to decode with skid-based back-pressure.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [XLEN-1:0]   mem_addr,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            hold_valid;
    fetch_pkt_t      hold_pkt, cur_pkt;
    logic            stall;
    logic [1:0]      unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    assign out_valid = hold_valid | rsp_valid_q;
    assign out_pc    = hold_valid ? hold_pkt.pc : rsp_pc_q;
    assign out_inst  = hold_valid ? hold_pkt.inst : mem_rdata;
    assign stall     = out_valid & ~out_ready;
    assign cur_pkt   = {out_pc, out_inst};
    assign mem_addr  = pc_q;

    fetch_skid u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (redirect_valid),
        .stall_i (stall),
        .pkt_i   (cur_pkt),
        .valid_o (hold_valid),
        .pkt_o   (hold_pkt)
    );

    // pc_q stays put while stalled so the ROM keeps re-reading the rsp slot.
    always_comb begin
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = rsp_valid_q;
        if (redirect_valid) begin
            pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
            rsp_valid_d = 1'b0;
        end else if (stall && !hold_valid) begin
            rsp_pc_d    = pc_q;
            rsp_valid_d = 1'b1;
        end else if (!stall) begin
            rsp_pc_d    = pc_q;
            rsp_valid_d = 1'b1;
            pc_d        = next_pc(pc_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: reset, stream, stall, redirect,
// async reset and a random ready/redirect soak.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_addr, mem_rdata, out_pc, out_inst;
    logic        out_valid;

    logic        r80_valid = 1'b0;
    logic [31:0] r80_pc = '0;
    logic [31:0] mem_addr80, mem_rdata80, out_pc80, out_inst80;
    logic        out_valid80;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];

    logic        o_valid;
    logic [31:0] o_pc, o_inst, o_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return {~a[15:0], a[15:2], 2'b11};
        endcase
    endfunction

    fetch_unit dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    fetch_unit #(.RESET_PC(32'h80)) dut80 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr80), .mem_rdata(mem_rdata80),
        .redirect_valid(r80_valid), .redirect_pc(r80_pc),
        .out_valid(out_valid80), .out_ready(out_ready),
        .out_pc(out_pc80), .out_inst(out_inst80)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata   <= mem_word(mem_addr);
        mem_rdata80 <= mem_word(mem_addr80);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got running want finished");
        $fatal(1);
    end

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        out_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
        o_valid = out_valid;
        o_pc = out_pc;
        o_inst = out_inst;
        o_addr = mem_addr;
    endtask

    function automatic logic [31:0] sb_pop();
        logic [31:0] e;
        if (exp_q.size() == 0) return 32'hxxxx_xxxx;
        e = exp_q.pop_front();
        if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
        return e;
    endfunction

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back({pc[31:2], 2'b00});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_restart(32'h0);
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        #2;
        checks += 3;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else passes++;
        if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr);
        else passes++;
        if (out_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", out_pc);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        sb_restart(32'h0);
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        ins = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0);
            void'(sb_pop());
            checks += 3;
            if (o_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, o_valid);
            else passes++;
            if (o_pc !== pcs[i]) $display("FAIL stream_pc[%0d]: got %h want %h", i, o_pc, pcs[i]);
            else passes++;
            if (o_inst !== ins[i]) $display("FAIL stream_inst[%0d]: got %h want %h", i, o_inst, ins[i]);
            else passes++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        do_reset();
        step(1'b1, 1'b0, '0);
        e = sb_pop();
        checks++;
        if (o_pc !== e) $display("FAIL stall_pre_pc: got %h want %h", o_pc, e);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0);
            checks += 3;
            if (o_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, o_valid);
            else passes++;
            if (o_pc !== 32'h4) $display("FAIL stall_pc[%0d]: got %h want 4", i, o_pc);
            else passes++;
            if (o_inst !== 32'h0010_0093) $display("FAIL stall_inst[%0d]: got %h want 00100093", i, o_inst);
            else passes++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0);
            e = sb_pop();
            checks += 3;
            if (o_valid !== 1'b1) $display("FAIL release_valid[%0d]: got %b want 1", i, o_valid);
            else passes++;
            if (o_pc !== e) $display("FAIL release_pc[%0d]: got %h want %h", i, o_pc, e);
            else passes++;
            if (o_inst !== mem_word(e)) $display("FAIL release_inst[%0d]: got %h want %h", i, o_inst, mem_word(e));
            else passes++;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        step(1'b1, 1'b1, 32'h100);
        e = sb_pop();
        sb_restart(32'h100);
        checks++;
        if (o_pc !== e) $display("FAIL redir_accept_pc: got %h want %h", o_pc, e);
        else passes++;
        step(1'b1, 1'b0, '0);
        checks += 2;
        if (o_valid !== 1'b0) $display("FAIL redir_bubble: got %b want 0", o_valid);
        else passes++;
        if (o_addr !== 32'h100) $display("FAIL redir_addr: got %h want 100", o_addr);
        else passes++;
        step(1'b1, 1'b0, '0);
        e = sb_pop();
        checks += 3;
        if (o_valid !== 1'b1) $display("FAIL redir_valid: got %b want 1", o_valid);
        else passes++;
        if (o_pc !== 32'h100) $display("FAIL redir_pc: got %h want 100", o_pc);
        else passes++;
        if (o_inst !== mem_word(e)) $display("FAIL redir_inst: got %h want %h", o_inst, mem_word(e));
        else passes++;
    endtask

    task automatic test_redirect_hold();
        logic [31:0] e;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h203);
        sb_restart(32'h203);
        step(1'b1, 1'b0, '0);
        checks += 2;
        if (o_valid !== 1'b0) $display("FAIL rhold_bubble: got %b want 0", o_valid);
        else passes++;
        if (o_addr !== 32'h200) $display("FAIL rhold_addr: got %h want 200", o_addr);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, '0);
            e = sb_pop();
            checks += 3;
            if (o_pc !== 32'h200 + 32'(4 * i)) $display("FAIL rhold_pc[%0d]: got %h want %h", i, o_pc, 32'h200 + 32'(4 * i));
            else passes++;
            if (o_pc !== e) $display("FAIL rhold_sb_pc[%0d]: got %h want %h", i, o_pc, e);
            else passes++;
            if (o_inst !== mem_word(e)) $display("FAIL rhold_inst[%0d]: got %h want %h", i, o_inst, mem_word(e));
            else passes++;
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        void'(sb_pop());
        sb_restart(32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        void'(sb_pop());
        checks++;
        if (o_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_last: got %h want fffffffc", o_pc);
        else passes++;
        step(1'b1, 1'b0, '0);
        void'(sb_pop());
        checks += 2;
        if (o_pc !== 32'h0) $display("FAIL wrap_zero_pc: got %h want 0", o_pc);
        else passes++;
        if (o_inst !== 32'h0000_0013) $display("FAIL wrap_zero_inst: got %h want 00000013", o_inst);
        else passes++;
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, '0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", out_valid);
        else passes++;
        if (mem_addr !== 32'h0) $display("FAIL arst_addr: got %h want 0", mem_addr);
        else passes++;
        if (out_pc !== 32'h0) $display("FAIL arst_pc: got %h want 0", out_pc);
        else passes++;
        if (mem_addr80 !== 32'h80) $display("FAIL arst_addr80: got %h want 80", mem_addr80);
        else passes++;
        if (out_valid80 !== 1'b0) $display("FAIL arst_valid80: got %b want 0", out_valid80);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        sb_restart(32'h0);
        step(1'b1, 1'b0, '0);
        void'(sb_pop());
        checks += 4;
        if (o_pc !== 32'h0 || o_valid !== 1'b1) $display("FAIL arst_restart: got %h/%b want 0/1", o_pc, o_valid);
        else passes++;
        if (out_pc80 !== 32'h80 || out_valid80 !== 1'b1) $display("FAIL arst80_first: got %h/%b want 80/1", out_pc80, out_valid80);
        else passes++;
        if (out_inst80 !== mem_word(32'h80)) $display("FAIL arst80_inst: got %h want %h", out_inst80, mem_word(32'h80));
        else passes++;
        step(1'b1, 1'b0, '0);
        void'(sb_pop());
        if (out_pc80 !== 32'h84) $display("FAIL arst80_second: got %h want 84", out_pc80);
        else passes++;
    endtask

    task automatic test_soak();
        logic        rdy, rv, p_valid, p_rdy, p_rv;
        logic [31:0] rpc, e, p_pc, p_inst;
        int          accepts;
        accepts = 0;
        p_valid = 1'b0;
        p_rdy = 1'b1;
        p_rv = 1'b0;
        p_pc = '0;
        p_inst = '0;
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 15) == 0);
            rpc = 32'($urandom_range(0, 4095));
            step(rdy, rv, rpc);
            if (p_rv) begin
                checks++;
                if (o_valid !== 1'b0) $display("FAIL soak_bubble[%0d]: got %b want 0", i, o_valid);
                else passes++;
            end else if (p_valid && !p_rdy) begin
                checks++;
                if (o_valid !== 1'b1 || o_pc !== p_pc || o_inst !== p_inst)
                    $display("FAIL soak_stable[%0d]: got %b/%h/%h want 1/%h/%h", i, o_valid, o_pc, o_inst, p_pc, p_inst);
                else passes++;
            end
            if (o_valid && rdy) begin
                e = sb_pop();
                accepts++;
                checks += 2;
                if (o_pc !== e) $display("FAIL soak_pc[%0d]: got %h want %h", i, o_pc, e);
                else passes++;
                if (o_inst !== mem_word(e)) $display("FAIL soak_inst[%0d]: got %h want %h", i, o_inst, mem_word(e));
                else passes++;
            end
            if (rv) sb_restart(rpc);
            p_valid = o_valid;
            p_rdy = rdy;
            p_rv = rv;
            p_pc = o_pc;
            p_inst = o_inst;
        end
        checks++;
        if (accepts < 200) $display("FAIL soak_accepts: got %0d want >=200", accepts);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_hold();
        test_wrap();
        test_async_reset();
        test_soak();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front-end: the requester side of the instruction ROM port. Drives a byte address into the synchronous-read instruction memory, pairs the returned 32-bit word with its PC, and presents a valid/ready instruction stream to decode. Supports consumer back-pressure without bubbles and branch/jump redirects, with a 1-cycle redirect penalty.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  32  byte address to instruction memory; driven directly from a register (no combinational input path).
- mem_rdata  in  32  memory word; valid in the cycle after mem_addr was sampled, reflecting the address presented in the previous cycle.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0 internally.
- out_valid  out  1  out_inst/out_pc hold a fetched instruction.
- out_ready  in  1  consumer accepts when out_valid & out_ready at a rising edge.
- out_pc  out  32  byte address of out_inst.
- out_inst  out  32  instruction word.

## Operation
- Registers: pc_q (drives mem_addr), rsp_valid, rsp_pc, hold_valid, hold_pc, hold_inst.
- Output mux: out_valid = hold_valid | rsp_valid; out_inst = hold_valid ? hold_inst : mem_rdata; out_pc = hold_valid ? hold_pc : rsp_pc.
- stall = out_valid & ~out_ready.
- Edge priority (highest first):
  - redirect_valid: pc_q <= {redirect_pc[31:2],2'b00}; rsp_valid <= 0; hold_valid <= 0. Any unaccepted instruction is squashed. Ignores stall.
  - stall & ~hold_valid (enter HOLD): hold_pc/hold_inst <= current out_pc/out_inst; hold_valid <= 1; rsp_pc <= pc_q; rsp_valid <= 1; pc_q unchanged. The memory keeps re-reading pc_q, so the rsp slot stays correct.
  - stall & hold_valid: no state change.
  - otherwise (advance): hold_valid <= 0; rsp_valid <= 1; rsp_pc <= pc_q; pc_q <= pc_q + 4.
- States are implied by the registers:
  - EMPTY: rsp_valid=0, hold_valid=0.
  - STREAM: rsp_valid=1, hold_valid=0.
  - HOLD: hold_valid=1.
- pc_q + 4 wraps modulo 2^32. No range checking; memory depth is handled outside this block.
- Memory is read-only and re-reads are side-effect free; this is the basis of the re-issue scheme.

## Timing
- Reset (asynchronous, immediate): pc_q=RESET_PC, so mem_addr=RESET_PC. rsp_valid=0, hold_valid=0, so out_valid=0. rsp_pc, hold_pc and hold_inst are 0, so out_pc=0.
- First edge after rst deasserts: rsp_pc=RESET_PC, pc_q=RESET_PC+4. out_valid=1 from the following cycle. Reset-to-first-instruction latency is 1 cycle.
- Throughput: 1 instruction/cycle with out_ready held high.
- Back-pressure: no bubble on stall release. The instruction after the held one appears in the cycle after the hold is accepted.
- Redirect at edge t: cycle t+1 has out_valid=0 and mem_addr=redirect_pc. Cycle t+2 has out_valid=1 and out_pc=redirect_pc.
- Redirect coincident with out_ready=1: the transfer of the current instruction still counts; redirect wins for all state.
- Redirect during HOLD: hold is discarded; same 1-bubble timing.
- rst asserted mid-stream: outputs return to reset values immediately, without waiting for a clock edge.
- out_valid never drops without an accept or a redirect.
- out_pc/out_inst are stable while stalled.

## Structure
- Shared package (cpu_pkg): XLEN=32, INST_W=32, ILEN_BYTES=4, default RESET_PC constant.
- One natural sub-module: fetch_skid, the 1-entry hold register with capture/release control. Everything else stays inline in fetch_unit.

## Test plan
- Reset/stream: memory words [0x0]=0x00000013, [0x4]=0x00100093, [0x8]=0x00200113; out_ready=1 → out_pc 0x0, 0x4, 0x8 on consecutive cycles starting 1 cycle after reset release; out_inst matches each word.
- Stall: deassert out_ready for 3 cycles while out_pc=0x4 → out_pc=0x4 and out_inst=0x00100093 held stable; on release, 0x8 follows in the very next cycle; no PC skipped or duplicated.
- Redirect: redirect_valid with redirect_pc=0x100 while streaming → next cycle out_valid=0 and mem_addr=0x100; following cycle out_pc=0x100.
- Redirect during HOLD, with redirect_pc=0x203 → hold dropped; out_pc=0x200 two cycles later; out_pc[1:0]=0 throughout.
- Async reset mid-stream, asserted between edges → out_valid=0 and mem_addr=RESET_PC with no clock edge; with RESET_PC=0x80 the stream restarts at 0x80.
- Random out_ready/redirect soak against a reference PC model → every accepted (pc, inst) pair matches memory; sequential PCs except immediately after a redirect.
